// File: rtl/median_scan_ctrl_pkg.sv
// Shared types and defaults for the 3x3 median scan controller.
// MEDIAN_BORDER_COPY_EN widens the scan to every pixel (see median_scan_ctrl.sv).
package median_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FILTER = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_WIDTH  = 430;
  localparam int DEF_LENGTH = 554;
  localparam int DEF_CW     = 9;
  localparam int DEF_RW     = 10;

  // A window centre on an outer row or column has no full 3x3 neighbourhood.
  function automatic logic is_border(input int col, input int row,
                                     input int width, input int length);
    return (col == 0) || (row == 0) || (col == width - 1) || (row == length - 1);
  endfunction

endpackage

// File: rtl/median_scan_ctrl_if.sv
// Handshake and coordinate bundle between the scan controller and its memory/filter pair.
// border_copy exists only when MEDIAN_BORDER_COPY_EN is defined.
interface median_scan_ctrl_if #(
  parameter int CW  = 9,
  parameter int RW_ = 10
) ();
  import median_scan_ctrl_pkg::*;

  logic           start;
  logic           input_done;
  logic           filter_done;
  logic           ok;
  logic [CW-1:0]  w;
  logic [RW_-1:0] l;
  logic           enable_filter;
  logic           rw;
  state_t         state;
  logic           busy;
  logic           finish;
`ifdef MEDIAN_BORDER_COPY_EN
  logic           border_copy;

  modport master (output start, input_done, filter_done, ok,
                  input  w, l, enable_filter, rw, state, busy, finish, border_copy);
  modport slave  (input  start, input_done, filter_done, ok,
                  output w, l, enable_filter, rw, state, busy, finish, border_copy);
`else
  modport master (output start, input_done, filter_done, ok,
                  input  w, l, enable_filter, rw, state, busy, finish);
  modport slave  (input  start, input_done, filter_done, ok,
                  output w, l, enable_filter, rw, state, busy, finish);
`endif

endinterface

// File: rtl/median_scan_ctrl_scan_counter.sv
// Raster column/row counter between first/last bounds; never advances past the last centre.
// Exposes the next coordinate's border flag so callers can register strobes in step with it.
module median_scan_ctrl_scan_counter
  import median_scan_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LENGTH  = DEF_LENGTH,
  parameter int CW      = DEF_CW,
  parameter int RW_     = DEF_RW,
  parameter int W_FIRST = 1,
  parameter int W_LAST  = DEF_WIDTH - 2,
  parameter int L_FIRST = 1,
  parameter int L_LAST  = DEF_LENGTH - 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_advance,
  output logic [CW-1:0]  o_col,
  output logic [RW_-1:0] o_row,
  output logic           o_last,
  output logic           o_border,
  output logic           o_border_nxt
);

  logic [CW-1:0]  r_col;
  logic [RW_-1:0] r_row;
  logic [CW-1:0]  w_col_nxt;
  logic [RW_-1:0] w_row_nxt;
  logic           w_last;

  assign w_last = (r_col == CW'(W_LAST)) && (r_row == RW_'(L_LAST));

  always_comb begin
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    if (i_load) begin
      w_col_nxt = CW'(W_FIRST);
      w_row_nxt = RW_'(L_FIRST);
    end else if (i_advance && !w_last) begin
      if (r_col == CW'(W_LAST)) begin
        w_col_nxt = CW'(W_FIRST);
        w_row_nxt = r_row + RW_'(1);
      end else begin
        w_col_nxt = r_col + CW'(1);
        w_row_nxt = r_row;
      end
    end else begin
      w_col_nxt = r_col;
      w_row_nxt = r_row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
    end
  end

  assign o_col        = r_col;
  assign o_row        = r_row;
  assign o_last       = w_last;
  assign o_border     = is_border(int'(r_col), int'(r_row), WIDTH, LENGTH);
  assign o_border_nxt = is_border(int'(w_col_nxt), int'(w_row_nxt), WIDTH, LENGTH);

endmodule

// File: rtl/median_scan_ctrl.sv
// Sequencer for the 3x3 median datapath: load, raster-scan centres, filter, write back.
// Define MEDIAN_BORDER_COPY_EN to visit every pixel and copy border pixels unfiltered.
module median_scan_ctrl
  import median_scan_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int LENGTH = DEF_LENGTH,
  parameter int CW     = DEF_CW,
  parameter int RW_    = DEF_RW
) (
  input  logic clk,
  input  logic rst_n,
  median_scan_ctrl_if.slave bus
);

`ifdef MEDIAN_BORDER_COPY_EN
  localparam bit BORDER_COPY = 1'b1;
  localparam int W_FIRST = 0;
  localparam int W_LAST  = WIDTH - 1;
  localparam int L_FIRST = 0;
  localparam int L_LAST  = LENGTH - 1;
`else
  localparam bit BORDER_COPY = 1'b0;
  localparam int W_FIRST = 1;
  localparam int W_LAST  = WIDTH - 2;
  localparam int L_FIRST = 1;
  localparam int L_LAST  = LENGTH - 2;
`endif

  if (WIDTH < 3 || LENGTH < 3) begin : g_size_err
    $error("median_scan_ctrl: WIDTH and LENGTH must both be at least 3");
  end

  state_t         r_state;
  state_t         w_next_state;
  logic           w_load;
  logic           w_advance;
  logic [CW-1:0]  w_col;
  logic [RW_-1:0] w_row;
  logic           w_last;
  logic           w_cur_border;
  logic           w_nxt_border;
  logic           r_enable_filter;
  logic           r_rw;
  logic           r_busy;
  logic           r_finish;

  median_scan_ctrl_scan_counter #(
    .WIDTH   (WIDTH),
    .LENGTH  (LENGTH),
    .CW      (CW),
    .RW_     (RW_),
    .W_FIRST (W_FIRST),
    .W_LAST  (W_LAST),
    .L_FIRST (L_FIRST),
    .L_LAST  (L_LAST)
  ) u_scan_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_advance    (w_advance),
    .o_col        (w_col),
    .o_row        (w_row),
    .o_last       (w_last),
    .o_border     (w_cur_border),
    .o_border_nxt (w_nxt_border)
  );

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next_state = LOAD;
        else           w_next_state = IDLE;
      end
      LOAD: begin
        if (bus.input_done) begin
          w_next_state = FILTER;
          w_load       = 1'b1;
        end else begin
          w_next_state = LOAD;
        end
      end
      FILTER: begin
        // Border centres skip the filter and go straight to the copy write-back.
        if (bus.filter_done || (BORDER_COPY && w_cur_border)) w_next_state = WRITE;
        else                                                  w_next_state = FILTER;
      end
      WRITE: begin
        if (bus.ok) begin
          if (w_last) begin
            w_next_state = DONE;
          end else begin
            w_next_state = FILTER;
            w_advance    = 1'b1;
          end
        end else begin
          w_next_state = WRITE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_enable_filter <= 1'b0;
      r_rw            <= 1'b0;
      r_busy          <= 1'b0;
      r_finish        <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_enable_filter <= (w_next_state == FILTER) && !(BORDER_COPY && w_nxt_border);
      r_rw            <= (w_next_state == WRITE);
      r_busy          <= (w_next_state != IDLE);
      r_finish        <= (w_next_state == DONE);
    end
  end

`ifdef MEDIAN_BORDER_COPY_EN
  logic r_border_copy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_border_copy <= 1'b0;
    else        r_border_copy <= (w_next_state == FILTER) && w_nxt_border;
  end

  assign bus.border_copy = r_border_copy;
`endif

  assign bus.w             = w_col;
  assign bus.l             = w_row;
  assign bus.state         = r_state;
  assign bus.enable_filter = r_enable_filter;
  assign bus.rw            = r_rw;
  assign bus.busy          = r_busy;
  assign bus.finish        = r_finish;

endmodule

// File: tb/tb_median_scan_ctrl.sv
// Directed-plus-random bench for median_scan_ctrl on a 5x4 image.
// Expected centres come from a nested-loop list built from the image bounds.
module tb_median_scan_ctrl;
  import median_scan_ctrl_pkg::*;

  localparam int W   = 5;
  localparam int L   = 4;
  localparam int CWB = 3;
  localparam int RWB = 3;
`ifdef MEDIAN_BORDER_COPY_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  typedef struct {
    int w;
    int l;
  } ctr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  ctr_t exp_q[$];

  int   wr_rise = 0;
  int   fin_rise = 0;
  int   en_rise = 0;
  int   bc_rise = 0;
  logic m_rw_q = 1'b0;
  logic m_fin_q = 1'b0;
  logic m_en_q = 1'b0;
  logic m_bc_q = 1'b0;

  median_scan_ctrl_if #(.CW(CWB), .RW_(RWB)) bus ();

  median_scan_ctrl #(.WIDTH(W), .LENGTH(L), .CW(CWB), .RW_(RWB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Edge counters for write strobes, finish pulses and filter/copy windows.
  always @(negedge clk) begin
    if (bus.rw && !m_rw_q) wr_rise <= wr_rise + 1;
    if (bus.finish && !m_fin_q) fin_rise <= fin_rise + 1;
    if (bus.enable_filter && !m_en_q) en_rise <= en_rise + 1;
`ifdef MEDIAN_BORDER_COPY_EN
    if (bus.border_copy && !m_bc_q) bc_rise <= bc_rise + 1;
    m_bc_q <= bus.border_copy;
`endif
    m_rw_q  <= bus.rw;
    m_fin_q <= bus.finish;
    m_en_q  <= bus.enable_filter;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit on_edge(input ctr_t c);
    return (c.w == 0) || (c.l == 0) || (c.w == W - 1) || (c.l == L - 1);
  endfunction

  function automatic void build_model();
    exp_q.delete();
    for (int r = 0; r < L; r++)
      for (int c = 0; c < W; c++) begin
        ctr_t e;
        e.w = c;
        e.l = r;
        if (BORDER || !on_edge(e)) exp_q.push_back(e);
      end
  endfunction

  task automatic pulse_input_done();
    bus.input_done = 1'b1;
    tick();
    bus.input_done = 1'b0;
  endtask

  // Walk the expected centre list; fix_d >= 0 fixes the filter delay, stop_at leaves in WRITE.
  task automatic run_scan(input int stop_at, input int fix_d, input bit strays);
    for (int i = 0; i < exp_q.size(); i++) begin
      ctr_t c;
      bit   bd;
      int   d;
      int   e;
      c  = exp_q[i];
      bd = BORDER && on_edge(c);
      chk("filter_state", bus.state, FILTER);
      chk("filter_w", bus.w, c.w);
      chk("filter_l", bus.l, c.l);
      chk("filter_en", bus.enable_filter, !bd);
      chk("filter_rw", bus.rw, 1'b0);
`ifdef MEDIAN_BORDER_COPY_EN
      chk("border_copy", bus.border_copy, bd);
`endif
      if (!bd) begin
        d = (fix_d >= 0) ? fix_d : $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
          if (strays) bus.ok = 1'($urandom_range(0, 1));
          tick();
          bus.ok = 1'b0;
          chk("wait_state", bus.state, FILTER);
          chk("wait_en", bus.enable_filter, 1'b1);
          chk("wait_w", bus.w, c.w);
          chk("wait_l", bus.l, c.l);
        end
        bus.filter_done = 1'b1;
      end
      tick();
      bus.filter_done = 1'b0;
      chk("write_state", bus.state, WRITE);
      chk("write_rw", bus.rw, 1'b1);
      chk("write_en", bus.enable_filter, 1'b0);
      chk("write_w", bus.w, c.w);
      chk("write_l", bus.l, c.l);
      if (i == stop_at) return;
      e = (fix_d >= 0) ? 0 : $urandom_range(0, 3);
      for (int k = 0; k < e; k++) begin
        if (strays) bus.filter_done = 1'($urandom_range(0, 1));
        tick();
        bus.filter_done = 1'b0;
        chk("write_hold", bus.state, WRITE);
        chk("write_hold_rw", bus.rw, 1'b1);
      end
      bus.ok = 1'b1;
      tick();
      bus.ok = 1'b0;
      if (i == exp_q.size() - 1) begin
        chk("done_state", bus.state, DONE);
        chk("done_finish", bus.finish, 1'b1);
        chk("done_busy", bus.busy, 1'b1);
        chk("done_rw", bus.rw, 1'b0);
      end
    end
  endtask

  task automatic check_idle_after_done();
    tick();
    chk("idle_state", bus.state, IDLE);
    chk("idle_finish", bus.finish, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_w_hold", bus.w, exp_q[exp_q.size()-1].w);
    chk("idle_l_hold", bus.l, exp_q[exp_q.size()-1].l);
  endtask

  initial begin
    int wr0;
    int fin0;
    int en0;
    int bc0;
    int n_border;
    int idx22;
    bus.start       = 1'b0;
    bus.input_done  = 1'b0;
    bus.filter_done = 1'b0;
    bus.ok          = 1'b0;
    build_model();
    n_border = 0;
    idx22    = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (on_edge(exp_q[i])) n_border++;
      if (exp_q[i].w == 2 && exp_q[i].l == 2) idx22 = i;
    end

    repeat (3) tick();
    chk("rst_state", bus.state, IDLE);
    chk("rst_w", bus.w, 0);
    chk("rst_l", bus.l, 0);
    chk("rst_en", bus.enable_filter, 1'b0);
    chk("rst_rw", bus.rw, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_finish", bus.finish, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", bus.state, IDLE);

    // Scan 1: minimum-latency handshakes.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("load_state", bus.state, LOAD);
    chk("load_busy", bus.busy, 1'b1);
    chk("load_rw", bus.rw, 1'b0);
    repeat (3) begin
      tick();
      chk("load_wait", bus.state, LOAD);
    end
    pulse_input_done();
    wr0 = wr_rise; fin0 = fin_rise; en0 = en_rise; bc0 = bc_rise;
    run_scan(-1, 0, 1'b0);
    check_idle_after_done();
    chk("write_entries", wr_rise - wr0, exp_q.size());
    chk("finish_pulses", fin_rise - fin0, 1);
    chk("filter_windows", en_rise - en0, exp_q.size() - (BORDER ? n_border : 0));
`ifdef MEDIAN_BORDER_COPY_EN
    chk("copy_windows", bc_rise - bc0, n_border);
`endif

    bus.ok = 1'b1;
    bus.filter_done = 1'b1;
    tick();
    bus.ok = 1'b0;
    bus.filter_done = 1'b0;
    chk("idle_strays", bus.state, IDLE);

    // Scan 2: start held high throughout, random delays and stray strobes.
    bus.start = 1'b1;
    tick();
    chk("load2_state", bus.state, LOAD);
    pulse_input_done();
    run_scan(-1, -1, 1'b1);
    tick();
    chk("idle2_state", bus.state, IDLE);
    tick();
    chk("restart_load", bus.state, LOAD);
    bus.start = 1'b0;

    // Scan 3: filter_done delayed ten cycles per centre.
    pulse_input_done();
    run_scan(-1, 10, 1'b0);
    check_idle_after_done();

    // Scan 4: asynchronous reset while writing centre (2,2).
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    pulse_input_done();
    run_scan(idx22, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_rw", bus.rw, 1'b0);
    chk("arst_state", bus.state, IDLE);
    chk("arst_w", bus.w, 0);
    chk("arst_l", bus.l, 0);
    chk("arst_busy", bus.busy, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", bus.state, IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
